// File: rtl/sha256_compress_core_pkg.sv
// Shared SHA-256 constants (k table, initial hash values), FSM state enum and round functions.
// SHA224_MODE_EN selects the SHA-224 initial hash value as IV.
package sha256_compress_core_pkg;

  typedef logic [31:0] word_t;
  // Index 0 is a / H0 and sits in the most significant word.
  typedef logic [0:7][31:0] work_t;

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} sha_state_t;

  localparam work_t IV_SHA256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam work_t IV_SHA224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`ifdef SHA224_MODE_EN
  localparam work_t IV = IV_SHA224;
`else
  localparam work_t IV = IV_SHA256;
`endif

  localparam word_t k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compress_core_if.sv
// Block handshake and digest bus between the host and the compression core.
interface sha256_compress_core_if #(parameter int IN_W = 512);
  import sha256_compress_core_pkg::*;

  logic [IN_W-1:0] block_in;
  logic            first_block;
  logic            block_valid;
  logic            block_ready;
  work_t           digest;
  logic            digest_valid;

  modport master (output block_in, first_block, block_valid,
                  input  block_ready, digest, digest_valid);
  modport slave  (input  block_in, first_block, block_valid,
                  output block_ready, digest, digest_valid);
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: current a..h plus W/K in, next a..h out.
module sha256_round
  import sha256_compress_core_pkg::*;
(
  input  work_t cur,
  input  word_t w_word,
  input  word_t k_word,
  output work_t nxt
);

  word_t t1;
  word_t t2;

  assign t1  = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + k_word + w_word;
  assign t2  = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
  assign nxt = {t1 + t2, cur[0], cur[1], cur[2], cur[3] + t1, cur[4], cur[5], cur[6]};

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 round engine: accepts a block, runs 64 rounds against an external schedule, folds into H.
// SHA224_MODE_EN switches to the SHA-224 IV and zeroes the last digest word.
module sha256_compress_core
  import sha256_compress_core_pkg::*;
#(
  parameter int IN_W   = 512,
  parameter int ROUNDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  sha256_compress_core_if.slave bus,
  output logic [IN_W-1:0] blk,
  output logic [31:0]     count,
  input  logic [31:0]     W,
  input  logic [31:0]     K,
  output word_t           W_Mem [0:15]
);

  sha_state_t state_q, state_d;
  logic [6:0] cnt_q;
  work_t      h_q, v_q, v_nxt, h_eff;
  logic       accept, round_en, update_en;

  sha256_round u_round (
    .cur    (v_q),
    .w_word (W),
    .k_word (K),
    .nxt    (v_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    round_en         = 1'b0;
    update_en        = 1'b0;
    bus.block_ready  = 1'b0;
    bus.digest_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.block_ready = 1'b1;
        if (bus.block_valid) begin
          accept  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        round_en = 1'b1;
        if (cnt_q == 7'(ROUNDS - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        update_en = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        bus.digest_valid = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a..h must start from the IV on a first block even though H only takes it at this same edge.
  assign h_eff = bus.first_block ? IV : h_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      blk   <= '0;
      h_q   <= IV;
      v_q   <= '0;
      for (int i = 0; i < 16; i++) W_Mem[i] <= '0;
    end else begin
      if (accept) begin
        blk   <= bus.block_in;
        cnt_q <= '0;
        h_q   <= h_eff;
        v_q   <= h_eff;
      end
      if (round_en) begin
        v_q               <= v_nxt;
        W_Mem[cnt_q[3:0]] <= W;
        cnt_q             <= cnt_q + 7'd1;
      end
      if (update_en) begin
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
      end
    end
  end

  assign count = {25'd0, cnt_q};

`ifdef SHA224_MODE_EN
  assign bus.digest = {h_q[0:6], 32'h0};
`else
  assign bus.digest = h_q;
`endif

endmodule
